// File: rtl/register_dump_reader.sv
// Streams a window of register-file words out over a valid/ready port and sums them.
// One word every 2 cycles with ready held high; first word valid 2 cycles after start; ready low stalls indefinitely.
module register_dump_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] rf_address,
  input  logic [DATA_WIDTH-1:0] rf_q,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic [ADDR_WIDTH-1:0] dout_addr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_COUNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [DATA_WIDTH-1:0] r_dout_data;
  logic [ADDR_WIDTH-1:0] r_dout_addr;
  logic                  r_dout_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_checksum;

  // The address counter only moves on start or a non-final handshake, so it
  // naturally keeps presenting the last fetched address while idle.
  assign rf_address = r_addr;
  assign dout_valid = r_dout_valid;
  assign dout_data  = r_dout_data;
  assign dout_addr  = r_dout_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign checksum   = r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_dout_data  <= '0;
      r_dout_addr  <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_checksum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr      <= first_addr;
            r_remaining <= (count == '0) ? FULL_COUNT : count;
            r_checksum  <= '0;
            r_busy      <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          r_dout_data  <= rf_q;
          r_dout_addr  <= r_addr;
          r_dout_valid <= 1'b1;
          r_state      <= PRESENT;
        end
        PRESENT: begin
          if (dout_ready) begin
            r_checksum   <= r_checksum + r_dout_data;
            r_remaining  <= r_remaining - ONE_COUNT;
            r_dout_valid <= 1'b0;
            if (r_remaining > ONE_COUNT) begin
              r_addr  <= r_addr + ADDR_WIDTH'(1);
              r_state <= FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_reader.sv
// Directed bench for register_dump_reader: full/wrapping dumps, stall, busy-start, async reset, checksum hold.
module tb_register_dump_reader;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NREG = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW:0]   count;
  logic [AW-1:0] rf_address;
  logic [DW-1:0] rf_q;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout_data;
  logic [AW-1:0] dout_addr;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  logic [DW-1:0] regs [NREG];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign rf_q = regs[rf_address];

  register_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .rf_address (rf_address),
    .rf_q       (rf_q),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_addr  (dout_addr),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one dump with dout_ready high; optionally pokes start while busy.
  task automatic run_dump(input int fa, input int cnt, input bit poke_start,
                          input logic [7:0] exp_sum, input string name);
    int n;
    int got;
    int dones;
    int first_valid;
    int last_hs;
    int exp_addr;
    n = (cnt == 0) ? NREG : cnt;
    got = 0; dones = 0; first_valid = -1; last_hs = -1;
    @(negedge clk);
    first_addr = fa[AW-1:0]; count = cnt[AW:0]; start = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && (got < n || dones == 0); cyc++) begin
      if (cyc == 0) begin
        check({name, "_clr_sum"}, checksum, 0);
        check({name, "_busy"}, busy, 1);
      end
      if (dout_valid && first_valid < 0) begin
        first_valid = cyc;
        check({name, "_latency"}, cyc, 1);
      end
      if (dout_valid && dout_ready) begin
        exp_addr = (fa + got) % NREG;
        check({name, "_addr"}, dout_addr, exp_addr);
        check({name, "_data"}, dout_data, regs[exp_addr]);
        if (last_hs >= 0) check({name, "_gap"}, cyc - last_hs, 2);
        last_hs = cyc;
        got++;
      end
      if (done) dones++;
      if (poke_start && cyc == 2) begin
        start = 1'b1; first_addr = 3'(fa + 3); count = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) begin
      if (done) dones++;
      @(negedge clk);
    end
    check({name, "_words"}, got, n);
    check({name, "_done_pulses"}, dones, 1);
    check({name, "_checksum"}, checksum, exp_sum);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int got;
    bit saw_valid;
    bit saw_done;
    reset = 1'b1; start = 1'b0; first_addr = '0; count = '0; dout_ready = 1'b0;
    for (int i = 0; i < NREG; i++) regs[i] = 8'hAA + 8'(i);

    #2;
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    check("rst_rf_address", rf_address, 0);
    check("rst_dout_data", dout_data, 0);
    check("rst_dout_addr", dout_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_dump(0, 0, 1'b0, 8'h6C, "full");
    check("idle_rf_address_hold", rf_address, 7);
    run_dump(6, 4, 1'b1, 8'hB6, "wrap");

    // Single word held off by dout_ready for five cycles.
    @(negedge clk);
    first_addr = 3'd3; count = 4'd1; start = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", dout_valid, 1);
      check("stall_data", dout_data, 8'hAD);
      check("stall_addr", dout_addr, 3);
      check("stall_no_done", done, 0);
      @(negedge clk);
    end
    check("stall_still_valid", dout_valid, 1);
    dout_ready = 1'b1;
    @(negedge clk);
    check("stall_done", done, 1);
    check("stall_valid_drop", dout_valid, 0);
    @(negedge clk);
    check("stall_done_once", done, 0);
    check("stall_idle", busy, 0);
    check("stall_checksum", checksum, 8'hAD);

    // Reset dropped between edges while the third word is presented.
    @(negedge clk);
    first_addr = 3'd0; count = 4'd0; start = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 40 && !(got == 2 && dout_valid); cyc++) begin
      if (dout_valid && dout_ready) got++;
      @(negedge clk);
    end
    check("abort_reached_word3", dout_addr, 2);
    check("abort_pre_valid", dout_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_valid", dout_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_checksum", checksum, 0);
    check("abort_rf_address", rf_address, 0);
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0; saw_done = 1'b0;
    repeat (8) begin
      if (dout_valid) saw_valid = 1'b1;
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("abort_no_valid", saw_valid, 0);
    check("abort_no_done", saw_done, 0);

    // Checksum holds across a register-file change until the next start.
    run_dump(0, 2, 1'b0, 8'h55, "pre_change");
    for (int i = 0; i < NREG; i++) regs[i] = 8'h10 + 8'(i);
    repeat (4) @(negedge clk);
    check("hold_checksum", checksum, 8'h55);
    run_dump(0, 2, 1'b0, 8'h21, "post_change");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
